// File: rtl/hsv_core_alu_shift_add_arb.sv
// Round-robin arbiter sharing the shift/add ALU substage between NUM_REQ issuers.
// Muxes the winner's operand bundle and tracks its ID through the substage register.
module hsv_core_alu_shift_add_arb #(
  parameter  int NUM_REQ    = 2,
  parameter  int ALU_DATA_W = 16,
  parameter  int WORD_W     = 32,
  parameter  int SHIFT_W    = 5,
  parameter  int ADDER_W    = 33,
  localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                                  clk_core,
  input  logic                                  rst_core,
  input  logic                                  stall,
  input  logic                                  flush_req,
  input  logic [NUM_REQ-1:0]                    req_valid_i,
  output logic [NUM_REQ-1:0]                    req_ready_o,
  input  logic [NUM_REQ-1:0][ALU_DATA_W-1:0]    req_alu_data_i,
  input  logic [NUM_REQ-1:0][WORD_W-1:0]        req_shift_lo_i,
  input  logic [NUM_REQ-1:0][WORD_W-1:0]        req_shift_hi_i,
  input  logic [NUM_REQ-1:0][SHIFT_W-1:0]       req_shift_cnt_i,
  input  logic [NUM_REQ-1:0][ADDER_W-1:0]       req_adder_a_i,
  input  logic [NUM_REQ-1:0][ADDER_W-1:0]       req_adder_b_i,
  output logic                                  sa_valid_o,
  output logic [ALU_DATA_W-1:0]                 sa_alu_data_o,
  output logic [WORD_W-1:0]                     sa_shift_lo_o,
  output logic [WORD_W-1:0]                     sa_shift_hi_o,
  output logic [SHIFT_W-1:0]                    sa_shift_cnt_o,
  output logic [ADDER_W-1:0]                    sa_adder_a_o,
  output logic [ADDER_W-1:0]                    sa_adder_b_o,
  input  logic                                  sa_valid_i,
  output logic [ID_W-1:0]                       res_id_o,
  output logic [NUM_REQ-1:0]                    res_valid_o
);

  logic [ID_W-1:0] rr_ptr_r;
  logic [ID_W-1:0] id_r;
  logic [ID_W-1:0] winner_s;
  logic [ID_W-1:0] scan_sel_s;
  logic            winner_found_s;
  logic            transfer_s;
  int unsigned     scan_idx_s;

  // Rotating priority scan starting at rr_ptr_r; first valid requester wins.
  always_comb begin
    winner_found_s = 1'b0;
    winner_s       = '0;
    scan_idx_s     = 0;
    scan_sel_s     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx_s = (int'(rr_ptr_r) + k) % NUM_REQ;
      scan_sel_s = scan_idx_s[ID_W-1:0];
      if (!winner_found_s && req_valid_i[scan_sel_s]) begin
        winner_found_s = 1'b1;
        winner_s       = scan_sel_s;
      end else begin
        winner_found_s = winner_found_s;
      end
    end
  end

  assign transfer_s = winner_found_s & ~stall & ~flush_req & ~rst_core;

  // Winner bundle to the substage; zeros when nobody is requesting.
  always_comb begin
    sa_alu_data_o  = '0;
    sa_shift_lo_o  = '0;
    sa_shift_hi_o  = '0;
    sa_shift_cnt_o = '0;
    sa_adder_a_o   = '0;
    sa_adder_b_o   = '0;
    if (winner_found_s) begin
      sa_alu_data_o  = req_alu_data_i[winner_s];
      sa_shift_lo_o  = req_shift_lo_i[winner_s];
      sa_shift_hi_o  = req_shift_hi_i[winner_s];
      sa_shift_cnt_o = req_shift_cnt_i[winner_s];
      sa_adder_a_o   = req_adder_a_i[winner_s];
      sa_adder_b_o   = req_adder_b_i[winner_s];
    end else begin
      sa_alu_data_o  = '0;
    end
  end

  // Handshake and result routing; reset forces all valids/readies low.
  always_comb begin
    req_ready_o = '0;
    res_valid_o = '0;
    sa_valid_o  = winner_found_s & ~flush_req & ~rst_core;
    res_id_o    = id_r;
    if (transfer_s) begin
      req_ready_o[winner_s] = 1'b1;
    end else begin
      req_ready_o = '0;
    end
    if (sa_valid_i && !rst_core) begin
      res_valid_o[id_r] = 1'b1;
    end else begin
      res_valid_o = '0;
    end
  end

  // Pointer advances only on a real transfer; id follows the substage's own enable.
  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      rr_ptr_r <= '0;
      id_r     <= '0;
    end else begin
      if (transfer_s) begin
        rr_ptr_r <= (winner_s == ID_W'(NUM_REQ - 1)) ? '0 : winner_s + ID_W'(1);
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
      if (!stall && winner_found_s) begin
        id_r <= winner_s;
      end else begin
        id_r <= id_r;
      end
    end
  end

endmodule

// File: tb/tb_hsv_core_alu_shift_add_arb.sv
// Scoreboard bench: expected grants are queued at issue and matched against the
// routed result one cycle later; a second instance covers three requesters.
module tb_hsv_core_alu_shift_add_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, stall, flush;
  int   checks   = 0;
  int   failures = 0;

  // Two-requester instance
  logic [1:0]        v2, rdy2, rv2;
  logic [1:0][15:0]  ad2;
  logic [1:0][31:0]  lo2, hi2;
  logic [1:0][4:0]   cnt2;
  logic [1:0][32:0]  aa2, ab2;
  logic              sav2, sub_v2;
  logic [15:0]       s_ad2;
  logic [31:0]       s_lo2, s_hi2;
  logic [4:0]        s_cnt2;
  logic [32:0]       s_aa2, s_ab2;
  logic [0:0]        rid2;

  hsv_core_alu_shift_add_arb #(.NUM_REQ(2)) dut2 (
    .clk_core(clk), .rst_core(rst), .stall(stall), .flush_req(flush),
    .req_valid_i(v2), .req_ready_o(rdy2),
    .req_alu_data_i(ad2), .req_shift_lo_i(lo2), .req_shift_hi_i(hi2),
    .req_shift_cnt_i(cnt2), .req_adder_a_i(aa2), .req_adder_b_i(ab2),
    .sa_valid_o(sav2), .sa_alu_data_o(s_ad2), .sa_shift_lo_o(s_lo2),
    .sa_shift_hi_o(s_hi2), .sa_shift_cnt_o(s_cnt2), .sa_adder_a_o(s_aa2),
    .sa_adder_b_o(s_ab2), .sa_valid_i(sub_v2), .res_id_o(rid2), .res_valid_o(rv2)
  );

  // Stand-in for the substage's one registered cycle
  always @(posedge clk) begin
    if (rst) sub_v2 <= 1'b0;
    else if (!stall) sub_v2 <= sav2;
  end

  // Three-requester instance, control only
  logic [2:0]        v3, rdy3, rv3;
  logic [2:0][15:0]  ad3;
  logic [2:0][31:0]  lo3, hi3;
  logic [2:0][4:0]   cnt3;
  logic [2:0][32:0]  aa3, ab3;
  logic              sav3, sub_v3;
  logic [15:0]       s_ad3;
  logic [31:0]       s_lo3, s_hi3;
  logic [4:0]        s_cnt3;
  logic [32:0]       s_aa3, s_ab3;
  logic [1:0]        rid3;

  hsv_core_alu_shift_add_arb #(.NUM_REQ(3)) dut3 (
    .clk_core(clk), .rst_core(rst), .stall(stall), .flush_req(flush),
    .req_valid_i(v3), .req_ready_o(rdy3),
    .req_alu_data_i(ad3), .req_shift_lo_i(lo3), .req_shift_hi_i(hi3),
    .req_shift_cnt_i(cnt3), .req_adder_a_i(aa3), .req_adder_b_i(ab3),
    .sa_valid_o(sav3), .sa_alu_data_o(s_ad3), .sa_shift_lo_o(s_lo3),
    .sa_shift_hi_o(s_hi3), .sa_shift_cnt_o(s_cnt3), .sa_adder_a_o(s_aa3),
    .sa_adder_b_o(s_ab3), .sa_valid_i(sub_v3), .res_id_o(rid3), .res_valid_o(rv3)
  );

  int res_q[$];
  bit prev_st = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic rand_ops2();
    for (int i = 0; i < 2; i++) begin
      ad2[i]  = 16'($urandom);
      lo2[i]  = $urandom;
      hi2[i]  = $urandom;
      cnt2[i] = 5'($urandom);
      aa2[i]  = {1'($urandom), $urandom};
      ab2[i]  = {1'($urandom), $urandom};
    end
  endtask

  // One cycle on the 2-requester DUT; w = expected winner, -1 when none.
  task automatic cyc2(input logic r, input logic [1:0] v, input logic st,
                      input logic fl, input int w, input string tag);
    logic [0:0] wi;
    logic       exp_sav;
    int         e;
    @(negedge clk);
    rst = r; v2 = v; stall = st; flush = fl;
    #1;
    if (r) begin
      check_eq({tag, "_ready"}, 64'(rdy2), 64'd0);
      check_eq({tag, "_sav"}, 64'(sav2), 64'd0);
      check_eq({tag, "_resv"}, 64'(rv2), 64'd0);
      res_q.delete();
      prev_st = 1'b0;
    end else begin
      if (!prev_st) begin
        if (res_q.size() > 0) begin
          e = res_q.pop_front();
          check_eq({tag, "_resid"}, 64'(rid2), 64'(e));
          check_eq({tag, "_resv"}, 64'(rv2), 64'(1) << e);
        end else begin
          check_eq({tag, "_resv0"}, 64'(rv2), 64'd0);
        end
      end
      exp_sav = (w >= 0) && !fl;
      check_eq({tag, "_ready"}, 64'(rdy2), (w >= 0 && !st && !fl) ? (64'(1) << w) : 64'd0);
      check_eq({tag, "_sav"}, 64'(sav2), 64'(exp_sav));
      if (w >= 0) begin
        wi = w[0:0];
        check_eq({tag, "_adda"}, 64'(s_aa2), 64'(aa2[wi]));
        check_eq({tag, "_addb"}, 64'(s_ab2), 64'(ab2[wi]));
        check_eq({tag, "_shlo"}, 64'(s_lo2), 64'(lo2[wi]));
        check_eq({tag, "_alud"}, 64'(s_ad2), 64'(ad2[wi]));
      end else begin
        check_eq({tag, "_zero"}, 64'(s_aa2), 64'd0);
      end
      if (exp_sav && !st) res_q.push_back(w);
      prev_st = st;
    end
  endtask

  task automatic cyc3(input logic [2:0] v, input int w, input string tag);
    @(negedge clk);
    rst = 1'b0; v3 = v; stall = 1'b0; flush = 1'b0;
    #1;
    check_eq(tag, 64'(rdy3), 64'(1) << w);
  endtask

  logic [2:0] seq3_v [7] = '{3'b101, 3'b101, 3'b101, 3'b101, 3'b111, 3'b111, 3'b111};
  int         seq3_w [7] = '{0, 2, 0, 2, 0, 1, 2};

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    v2 = '0; v3 = '0; sub_v3 = 1'b0;
    ad3 = '0; lo3 = '0; hi3 = '0; cnt3 = '0; aa3 = '0; ab3 = '0;
    rand_ops2();

    cyc2(1'b1, 2'b11, 1'b0, 1'b0, -1, "rst0");
    cyc2(1'b1, 2'b11, 1'b0, 1'b0, -1, "rst1");

    for (int i = 0; i < 4; i++) begin
      rand_ops2();
      cyc2(1'b0, 2'b11, 1'b0, 1'b0, i % 2, "rr");
    end

    for (int i = 0; i < 3; i++) cyc2(1'b0, 2'b10, 1'b1, 1'b0, 1, "stall");
    cyc2(1'b0, 2'b10, 1'b0, 1'b0, 1, "stall_rel");

    cyc2(1'b0, 2'b11, 1'b0, 1'b1, 0, "flush");
    cyc2(1'b0, 2'b11, 1'b0, 1'b0, 0, "post_flush");

    aa2 = '0; ab2 = '0;
    aa2[1] = 33'd5; ab2[1] = 33'd3;
    cyc2(1'b0, 2'b10, 1'b0, 1'b0, 1, "mux");
    cyc2(1'b0, 2'b00, 1'b0, 1'b0, -1, "idle");
    cyc2(1'b0, 2'b00, 1'b0, 1'b0, -1, "idle2");

    for (int i = 0; i < 4; i++) begin
      rand_ops2();
      cyc2(1'b0, 2'b11, 1'b0, 1'b0, i % 2, "rand");
    end
    cyc2(1'b0, 2'b00, 1'b0, 1'b0, -1, "drain");

    for (int i = 0; i < 7; i++) cyc3(seq3_v[i], seq3_w[i], "rr3");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
